// File: rtl/rfft_pkg.sv
// Shared types and constants for the 256-point radix-4 FFT sequencer.
// The select tables map a butterfly's bank rotation onto the datapath mux codes.
package rfft_pkg;

    localparam int N_PTS    = 256;
    localparam int N_STAGES = 4;
    localparam int BANK_AW  = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CALC   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_UNLOAD = 3'd4,
        ST_FLUSH  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Indexed by rotation; each entry is {m11, m12[1:0], m13[1:0], m14}
    localparam logic [3:0][5:0] RD_SEL = {6'b111111, 6'b010100, 6'b101011, 6'b000000};
    // Indexed by rotation; each entry is {m21, m22, m23, m24}
    localparam logic [3:0][3:0] WR_SEL = {4'b1111, 4'b0101, 4'b1010, 4'b0000};

    // Base-4 digit sum mod 4 of a 3-digit index: this is the bank rotation
    function automatic logic [1:0] ds3(input logic [5:0] x);
        return x[1:0] + x[3:2] + x[5:4];
    endfunction

endpackage

// File: rtl/rfft_agu.sv
// Butterfly address generator: for stage s and butterfly k, produces the four
// per-bank read addresses, the bank rotation and the twiddle exponent base.
module rfft_agu
    import rfft_pkg::*;
(
    input  logic [1:0]             stage,
    input  logic [5:0]             k,
    output logic [4*BANK_AW-1:0]   addr,
    output logic [1:0]             rot,
    output logic [7:0]             tw_base
);

    logic [2:0] sh_s;
    logic [7:0] k8_s;
    logic [7:0] mask_s;
    logic [7:0] lo_s;
    logic [7:0] hi_s;
    logic [7:0] n_s;
    logic [1:0] bidx_s;

    // Leg j inserts digit j at base-4 position 3-s; leg j lives in bank rot+j
    always_comb begin
        sh_s    = {~stage, 1'b0};
        k8_s    = {2'b00, k};
        mask_s  = (8'd1 << sh_s) - 8'd1;
        lo_s    = k8_s & mask_s;
        hi_s    = (k8_s & ~mask_s) << 2;
        rot     = ds3(k);
        tw_base = lo_s << {stage, 1'b0};
        addr    = {(4*BANK_AW){1'b0}};
        n_s     = 8'd0;
        bidx_s  = 2'd0;
        for (int j = 0; j < 4; j++) begin
            n_s    = hi_s | ({6'd0, 2'(j)} << sh_s) | lo_s;
            bidx_s = rot + 2'(j);
            addr[BANK_AW*bidx_s +: BANK_AW] = n_s[7:2];
        end
    end

endmodule

// File: rtl/rfft_ctrl256.sv
// Sequencer for the 256-point radix-4 FFT datapath: load, four in-place
// compute stages with delayed write-back, unload in digit-reversed order.
module rfft_ctrl256
    import rfft_pkg::*;
#(
    parameter int ADDR_BIT = 6,
    parameter int RD_LAT   = 1,
    parameter int PE_LAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            ld_rot,
    output logic                  out_valid,
    output logic [1:0]            out_rot,
    output logic                  en,
    output logic                  we,
    output logic                  re,
    output logic                  m0,
    output logic                  m11,
    output logic [1:0]            m12,
    output logic [1:0]            m13,
    output logic                  m14,
    output logic                  m21,
    output logic                  m22,
    output logic                  m23,
    output logic                  m24,
    output logic                  bypass_en,
    output logic [4*ADDR_BIT-1:0] addr_read,
    output logic [4*ADDR_BIT-1:0] addr_write,
    output logic [7:0]            tw_base,
    output logic [1:0]            stage
);

    localparam int          AW     = 4 * ADDR_BIT;
    localparam int          WLAT   = RD_LAT + PE_LAT;
    localparam logic [5:0]  K_LAST = 6'(N_PTS / 4 - 1);
    localparam logic [1:0]  S_LAST = 2'(N_STAGES - 1);

    state_t     state_r, state_n;
    logic [5:0] k_r, k_n;
    logic [1:0] stage_r, stage_n;
    logic [3:0] dcnt_r, dcnt_n;

    logic [AW-1:0] agu_addr_s;
    logic [1:0]    agu_rot_s;
    logic [7:0]    agu_tw_s;

    logic          wv_r   [WLAT];
    logic [AW-1:0] wa_r   [WLAT];
    logic [3:0]    ws_r   [WLAT];
    logic          ov_r   [RD_LAT];
    logic [1:0]    orot_r [RD_LAT];

    rfft_agu u_agu (
        .stage   (stage_r),
        .k       (k_r),
        .addr    (agu_addr_s),
        .rot     (agu_rot_s),
        .tw_base (agu_tw_s)
    );

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            k_r     <= 6'd0;
            stage_r <= 2'd0;
            dcnt_r  <= 4'd0;
        end else begin
            state_r <= state_n;
            k_r     <= k_n;
            stage_r <= stage_n;
            dcnt_r  <= dcnt_n;
        end
    end

    // Next-state and counter sequencing; counters wrap only on state exit
    always_comb begin
        state_n = state_r;
        k_n     = k_r;
        stage_n = stage_r;
        dcnt_n  = dcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_LOAD;
                    k_n     = 6'd0;
                    stage_n = 2'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid && k_r == K_LAST) begin
                    state_n = ST_CALC;
                    k_n     = 6'd0;
                end else if (in_valid) begin
                    k_n = k_r + 6'd1;
                end else begin
                    k_n = k_r;
                end
            end
            ST_CALC: begin
                if (k_r == K_LAST) begin
                    state_n = ST_DRAIN;
                    k_n     = 6'd0;
                    dcnt_n  = 4'd0;
                end else begin
                    k_n = k_r + 6'd1;
                end
            end
            ST_DRAIN: begin
                if (dcnt_r == 4'(WLAT - 1)) begin
                    dcnt_n  = 4'd0;
                    state_n = (stage_r == S_LAST) ? ST_UNLOAD : ST_CALC;
                    stage_n = stage_r + 2'd1;
                end else begin
                    dcnt_n = dcnt_r + 4'd1;
                end
            end
            ST_UNLOAD: begin
                if (k_r == K_LAST) begin
                    state_n = ST_FLUSH;
                    k_n     = 6'd0;
                    dcnt_n  = 4'd0;
                end else begin
                    k_n = k_r + 6'd1;
                end
            end
            ST_FLUSH: begin
                if (dcnt_r == 4'(RD_LAT - 1)) begin
                    state_n = ST_DONE;
                    dcnt_n  = 4'd0;
                end else begin
                    dcnt_n = dcnt_r + 4'd1;
                end
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Write-side delay line: read issue info resurfaces when the PE result is ready
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WLAT; i++) begin
                wv_r[i] <= 1'b0;
                wa_r[i] <= {AW{1'b0}};
                ws_r[i] <= 4'd0;
            end
        end else begin
            wv_r[0] <= (state_r == ST_CALC);
            wa_r[0] <= agu_addr_s;
            ws_r[0] <= WR_SEL[agu_rot_s];
            for (int i = 1; i < WLAT; i++) begin
                wv_r[i] <= wv_r[i-1];
                wa_r[i] <= wa_r[i-1];
                ws_r[i] <= ws_r[i-1];
            end
        end
    end

    // Unload qualifier delay line, matched to the RAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                ov_r[i]   <= 1'b0;
                orot_r[i] <= 2'd0;
            end
        end else begin
            ov_r[0]   <= (state_r == ST_UNLOAD);
            orot_r[0] <= ds3(k_r);
            for (int i = 1; i < RD_LAT; i++) begin
                ov_r[i]   <= ov_r[i-1];
                orot_r[i] <= orot_r[i-1];
            end
        end
    end

    // Datapath control decode
    always_comb begin
        busy       = (state_r != ST_IDLE);
        done       = (state_r == ST_DONE);
        bypass_en  = 1'b1;
        ld_rot     = 2'd0;
        en         = 1'b0;
        we         = 1'b0;
        re         = 1'b0;
        m0         = 1'b0;
        {m11, m12, m13, m14} = 6'd0;
        {m21, m22, m23, m24} = 4'd0;
        addr_read  = {AW{1'b0}};
        addr_write = {AW{1'b0}};
        tw_base    = 8'd0;
        stage      = stage_r;
        out_valid  = ov_r[RD_LAT-1];
        out_rot    = orot_r[RD_LAT-1];
        case (state_r)
            ST_LOAD: begin
                ld_rot     = ds3(k_r);
                en         = in_valid;
                we         = in_valid;
                addr_write = {4{k_r}};
            end
            ST_CALC, ST_DRAIN: begin
                bypass_en  = 1'b0;
                we         = wv_r[WLAT-1];
                m0         = wv_r[WLAT-1];
                addr_write = wa_r[WLAT-1];
                {m21, m22, m23, m24} = ws_r[WLAT-1] & {4{wv_r[WLAT-1]}};
                if (state_r == ST_CALC) begin
                    re        = 1'b1;
                    addr_read = agu_addr_s;
                    tw_base   = agu_tw_s;
                    {m11, m12, m13, m14} = RD_SEL[agu_rot_s];
                end else begin
                    re = 1'b0;
                end
                en = re | we;
            end
            ST_UNLOAD: begin
                en        = 1'b1;
                re        = 1'b1;
                addr_read = {4{k_r}};
            end
            default: begin
                en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rfft_ctrl256.sv
// Directed bench for rfft_ctrl256 with a behavioural 4-bank RAM + radix-4 PE
// model used to push an impulse through a complete transform.
module tb_rfft_ctrl256;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic        busy, done, out_valid, en, we, re, m0;
    logic [1:0]  ld_rot, out_rot, m12, m13, stage;
    logic        m11, m14, m21, m22, m23, m24, bypass_en;
    logic [23:0] addr_read, addr_write;
    logic [7:0]  tw_base;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rfft_ctrl256 dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .busy(busy), .done(done), .ld_rot(ld_rot), .out_valid(out_valid),
        .out_rot(out_rot), .en(en), .we(we), .re(re), .m0(m0),
        .m11(m11), .m12(m12), .m13(m13), .m14(m14),
        .m21(m21), .m22(m22), .m23(m23), .m24(m24),
        .bypass_en(bypass_en), .addr_read(addr_read), .addr_write(addr_write),
        .tw_base(tw_base), .stage(stage)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] dsum(input int x);
        return 2'(((x % 4) + ((x / 4) % 4) + ((x / 16) % 4)) % 4);
    endfunction

    // Behavioural RAM banks and PE (complex integer samples)
    int mre [4][64];
    int mim [4][64];
    int rre [4];
    int rim [4];
    int xr [4];
    int xi [4];
    int yr [4];
    int yi [4];
    logic [1:0] rrot;
    logic [1:0] rotw;
    bit golden_on = 1'b0;
    int ucnt      = 0;
    int ov_cycles = 0;

    always @(negedge clk) begin
        if (golden_on && out_valid) begin
            ov_cycles++;
            for (int b = 0; b < 4; b++) begin
                chk("unl_re", rre[b], 32'd1);
                chk("unl_im", rim[b], 32'd0);
            end
            chk("unl_rot", 32'(out_rot), 32'(dsum(ucnt)));
            ucnt++;
        end
        if (we && !m0) begin
            for (int j = 0; j < 4; j++) begin
                mre[j][addr_write[6*j +: 6]] = ((4 * int'(addr_write[5:0]) + ((j - int'(ld_rot)) & 3)) == 0) ? 1 : 0;
                mim[j][addr_write[6*j +: 6]] = 0;
            end
        end
        if (we && m0) begin
            for (int j = 0; j < 4; j++) begin
                xr[j] = rre[(int'(rrot) + j) & 3];
                xi[j] = rim[(int'(rrot) + j) & 3];
            end
            for (int q = 0; q < 4; q++) begin
                yr[q] = 0;
                yi[q] = 0;
                for (int j = 0; j < 4; j++) begin
                    case ((q * j) & 3)
                        0: begin yr[q] += xr[j];  yi[q] += xi[j];  end
                        1: begin yr[q] += xi[j];  yi[q] -= xr[j];  end
                        2: begin yr[q] -= xr[j];  yi[q] -= xi[j];  end
                        default: begin yr[q] -= xi[j]; yi[q] += xr[j]; end
                    endcase
                end
            end
            rotw = {m22, m21};
            for (int b = 0; b < 4; b++) begin
                mre[b][addr_write[6*b +: 6]] = yr[(b - int'(rotw)) & 3];
                mim[b][addr_write[6*b +: 6]] = yi[(b - int'(rotw)) & 3];
            end
        end
        if (re) begin
            for (int b = 0; b < 4; b++) begin
                rre[b] = mre[b][addr_read[6*b +: 6]];
                rim[b] = mim[b][addr_read[6*b +: 6]];
            end
            rrot = m12;
        end
    end

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
        tick();
    endtask

    initial begin
        int first_re;
        int done_cnt;
        int done_at;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        repeat (3) tick();
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_done",   32'(done),       32'd0);
        chk("rst_en",     32'(en | we | re | m0), 32'd0);
        chk("rst_bypass", 32'(bypass_en),  32'd1);
        chk("rst_ovalid", 32'(out_valid),  32'd0);
        chk("rst_raddr",  32'(addr_read),  32'd0);
        chk("rst_waddr",  32'(addr_write), 32'd0);
        chk("rst_tw",     32'(tw_base),    32'd0);
        rst = 1'b0;

        // Load with in_valid alternating, phase 1 in the start cycle
        start = 1'b1; in_valid = 1'b1;
        first_re = 0;
        for (int c = 1; c <= 2000 && first_re == 0; c++) begin
            tick();
            start = 1'b0;
            in_valid = (c % 2 == 0);
            #1;
            if (c == 10) begin
                chk("ld4_rot",  32'(ld_rot),     32'd1);
                chk("ld4_addr", 32'(addr_write), {8'd0, 6'd4, 6'd4, 6'd4, 6'd4});
                chk("ld4_we",   32'(we),         32'd1);
            end
            if (c == 12) begin
                chk("ld5_rot",  32'(ld_rot),     32'd2);
                chk("ld5_addr", 32'(addr_write), {8'd0, 6'd5, 6'd5, 6'd5, 6'd5});
            end
            if (c == 13) chk("ld_idle_we", 32'(we), 32'd0);
            if (re && first_re == 0) first_re = c;
        end
        chk("load_len", 32'(first_re - 1), 32'd128);
        in_valid = 1'b1;
        wait_done("t2_done", 1000);

        // Reset in the middle of stage 2, butterfly 17
        start = 1'b1;
        for (int c = 1; c <= 212; c++) begin
            tick();
            start = 1'b0;
        end
        chk("s2k17_stage", 32'(stage),     32'd2);
        chk("s2k17_tw",    32'(tw_base),   32'd16);
        chk("s2k17_raddr", 32'(addr_read), {8'd0, 6'd17, 6'd16, 6'd19, 6'd18});
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("mid_rst_busy",   32'(busy),         32'd0);
        chk("mid_rst_ram",    32'(en | we | re), 32'd0);
        chk("mid_rst_bypass", 32'(bypass_en),    32'd1);
        tick();
        chk("rst_start_ign",  32'(busy),         32'd0);

        // Full transform of an impulse, with a stray start during CALC
        golden_on = 1'b1;
        start = 1'b1; in_valid = 1'b1;
        done_cnt = 0; done_at = 0;
        for (int c = 1; c <= 420; c++) begin
            tick();
            start = (c == 100);
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (c == 65) begin
                chk("s0k0_raddr", 32'(addr_read), {8'd0, 6'd48, 6'd32, 6'd16, 6'd0});
                chk("s0k0_tw",    32'(tw_base),   32'd0);
                chk("s0k0_rd",    32'({re, bypass_en, stage}), {28'd0, 1'b1, 1'b0, 2'd0});
            end
            if (c == 66) begin
                chk("s0k0_waddr", 32'(addr_write), {8'd0, 6'd48, 6'd32, 6'd16, 6'd0});
                chk("s0k0_wr",    32'({we, m0}),   32'd3);
            end
            if (c == 323) begin
                chk("s3k63_sel",   32'({m11, m12, m13, m14}), {26'd0, 6'b101011});
                chk("s3k63_tw",    32'(tw_base),   32'd0);
                chk("s3k63_raddr", 32'(addr_read), {8'd0, 6'd63, 6'd63, 6'd63, 6'd63});
                chk("s3k63_stage", 32'(stage),     32'd3);
            end
            if (c == 324) begin
                chk("drain_re", 32'(re), 32'd0);
                chk("drain_we", 32'(we), 32'd1);
            end
        end
        golden_on = 1'b0;
        chk("done_at",   32'(done_at),   32'd390);
        chk("done_cnt",  32'(done_cnt),  32'd1);
        chk("ov_cycles", 32'(ov_cycles), 32'd64);
        chk("unl_words", 32'(ucnt),      32'd64);
        chk("end_idle",  32'(busy),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
